shared_chunk_adder_ctrl: RTL and testbench

Sequences one narrow CHUNK-bit adder (Generic_Adder instantiated with WIDTH=CHUNK) to perform full WIDTH-bit additions with carry-in/carry-out. The adder is shared between two requesters under round-robin arbitration. Operands are processed chunk by chunk, least significant chunk first, with a registered inter-chunk carry. This trades adder area for latency in slow-control and housekeeping arithmetic paths.

---
 rtl/shared_chunk_adder_ctrl.sv | 169 ++++++++++++++++
 tb/tb_shared_chunk_adder_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_chunk_adder_ctrl.sv
// ---------------------------------------------------------------------------
// shared_chunk_adder_ctrl
//
// Performs full WIDTH-bit additions (A + B + ci) using a single CHUNK-bit
// adder that is stepped across the operands, least significant chunk first,
// with a registered carry between chunks. Two requesters share the unit under
// round-robin arbitration.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active-high
//   req_i    request level, bit n = requester n (sampled only in IDLE)
//   a0_i/b0_i  requester 0 operands
//   a1_i/b1_i  requester 1 operands
//   ci_i     per-requester carry-in
//   busy_o   high while an addition is in RUN or DONE
//   done_o   one-hot completion pulse on the owning requester (one cycle)
//   q_o      sum, updated only at completion and held afterwards
//   co_o     final carry-out, same timing as q_o
// ---------------------------------------------------------------------------

// Plain ripple adder; instantiated once at chunk width by the controller.
module Generic_Adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  assign {CO, Q} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CI};

endmodule

module shared_chunk_adder_ctrl #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [1:0]       ci_i,
  output logic             busy_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] q_o,
  output logic             co_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_owner;
  logic             r_last;

  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_last_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_co;

  // Ties go to whoever was not served last; a lone request wins outright.
  assign w_gnt_valid  = |req_i;
  assign w_gnt_id     = (req_i == 2'b11) ? ~r_last : req_i[1];
  assign w_last_chunk = (r_cnt == LAST);

  // Operands are shifted right one chunk per RUN cycle, so the adder always
  // sees the low chunk; this equals selecting chunk k by the counter.
  Generic_Adder #(
    .WIDTH (CHUNK)
  ) u_adder (
    .A  (r_opa[CHUNK-1:0]),
    .B  (r_opb[CHUNK-1:0]),
    .CI (r_carry),
    .Q  (w_sum),
    .CO (w_co)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_chunk) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 2'b00;
      q_o     <= '0;
      co_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_opa   <= w_gnt_id ? a1_i : a0_i;
            r_opb   <= w_gnt_id ? b1_i : b0_i;
            r_carry <= ci_i[w_gnt_id];
            r_owner <= w_gnt_id;
            r_cnt   <= '0;
            busy_o  <= 1'b1;
          end
        end
        S_RUN: begin
          r_opa   <= r_opa >> CHUNK;
          r_opb   <= r_opb >> CHUNK;
          // Result chunks enter at the top and move down; after NCHUNK
          // steps chunk 0 sits in the least significant position.
          r_res   <= {w_sum, r_res[WIDTH-1:CHUNK]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last_chunk) begin
            q_o    <= {w_sum, r_res[WIDTH-1:CHUNK]};
            co_o   <= w_co;
            done_o <= r_owner ? 2'b10 : 2'b01;
          end
        end
        S_DONE: begin
          done_o <= 2'b00;
          busy_o <= 1'b0;
          r_last <= r_owner;
        end
        default: begin
          done_o <= 2'b00;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_chunk_adder_ctrl.sv
module tb_shared_chunk_adder_ctrl;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       req_i;
  logic [WIDTH-1:0] a0_i, b0_i, a1_i, b1_i;
  logic [1:0]       ci_i;
  logic             busy_o;
  logic [1:0]       done_o;
  logic [WIDTH-1:0] q_o;
  logic             co_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         owner;
    logic [63:0] q;
    logic        co;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  shared_chunk_adder_ctrl #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .a0_i   (a0_i),
    .b0_i   (b0_i),
    .a1_i   (a1_i),
    .b1_i   (b1_i),
    .ci_i   (ci_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .q_o    (q_o),
    .co_o   (co_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_done"}, 64'(done_o), 64'd0);
    chk({name, "_q"},    q_o,         64'd0);
    chk({name, "_co"},   64'(co_o),   64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && done_o != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_onehot", 64'(done_o), 64'(2'b01 << mon_e.owner));
        chk("sum",         q_o,         mon_e.q);
        chk("carry_out",   64'(co_o),   64'(mon_e.co));
        chk("latency",     64'(cyc),    64'(mon_e.gcyc + NCHUNK));
      end
    end
  end

  task automatic wait_busy(input logic lvl, output bit ok);
    ok = 1'b0;
    if (busy_o === lvl) begin
      ok = 1'b1;
      return;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (busy_o === lvl) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout: busy_o=%b required %b", busy_o, lvl);
  endtask

  // Waits for the next grant, records the hand-computed expectation, then
  // follows the operation to its done pulse and drops the served request.
  task automatic serve(input int own, input logic [63:0] eq, input logic eco,
                       input bit scramble, input bit midreset);
    bit ok;
    wait_busy(1'b0, ok);
    if (!ok) return;
    wait_busy(1'b1, ok);
    if (!ok) return;
    sb.push_back('{own, eq, eco, cyc});
    if (midreset) begin
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      req_i = 2'b00;
      #1;
      chk_reset_outputs("midrst");
      void'(sb.pop_back());
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("midrst_hold");
      rst_i = 1'b0;
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (scramble) a0_i = {$urandom, $urandom};
      if (done_o != 2'b00) begin
        req_i = req_i & ~done_o;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: done_o=%b required nonzero", done_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    req_i = 2'b00;
    ci_i  = 2'b00;
    a0_i  = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk_reset_outputs("idle");
    end

    // Single add, carry crosses chunk 0 -> 1
    a0_i = 64'h0000_0000_0000_FFFF; b0_i = 64'h1; ci_i = 2'b00;
    req_i = 2'b01;
    serve(0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);

    // Full wrap through every chunk from requester 1
    a1_i = 64'hFFFF_FFFF_FFFF_FFFF; b1_i = 64'h0; ci_i = 2'b10;
    req_i = 2'b10;
    serve(1, 64'h0, 1'b1, 1'b0, 1'b0);

    // Round-robin with both requesting; last served was 1
    a0_i = 64'd5; b0_i = 64'd7; ci_i = 2'b00;
    a1_i = 64'h8000_0000_0000_0000; b1_i = 64'h8000_0000_0000_0000;
    req_i = 2'b11;
    serve(0, 64'd12, 1'b0, 1'b0, 1'b0);
    req_i[0] = 1'b1;
    serve(1, 64'h0, 1'b1, 1'b0, 1'b0);
    req_i[1] = 1'b1;
    serve(0, 64'd12, 1'b0, 1'b0, 1'b0);
    serve(1, 64'h0, 1'b1, 1'b0, 1'b0);

    // Operand a0 scrambled throughout RUN; result uses latched values
    a0_i = 64'h0123_4567_89AB_CDEF; b0_i = 64'hFEDC_BA98_7654_3210; ci_i = 2'b01;
    req_i = 2'b01;
    serve(0, 64'h0, 1'b1, 1'b1, 1'b0);

    // Reset during chunk 2
    a0_i = 64'h1234; b0_i = 64'h1; ci_i = 2'b00;
    req_i = 2'b01;
    serve(0, 64'h1235, 1'b0, 1'b0, 1'b1);

    // Fresh tie after reset: requester 0 must win again
    a0_i = 64'h0000_FFFF_0000_FFFF; b0_i = 64'h0000_0001_0000_0001;
    a1_i = 64'hFFFF_0000_FFFF_0000; b1_i = 64'h0001_0000_0001_0000;
    ci_i = 2'b00;
    req_i = 2'b11;
    serve(0, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    serve(1, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);

    repeat (8) @(negedge clk_i);
    chk("pending_expectations", 64'(sb.size()), 64'd0);
    chk("final_idle_busy", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
